// File: rtl/aes_req_arbiter.sv
// Two-requester round-robin front end for a single AES_top core: latches the winning block,
// drives core_en, returns the ciphertext by valid/ready. Optional WAIT timeout: AES_TIMEOUT_EN.
module aes_req_arbiter #(
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic         AES_clk,
  input  logic         AES_rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [127:0] req0_data,
  input  logic [127:0] req0_key,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [127:0] req1_data,
  input  logic [127:0] req1_key,
  output logic         resp0_valid,
  input  logic         resp0_ready,
  output logic         resp1_valid,
  input  logic         resp1_ready,
  output logic [127:0] resp_data,
  output logic         resp_err,
  output logic         core_en,
  output logic [127:0] core_data_in,
  output logic [127:0] core_key_in,
  input  logic [127:0] core_data_out,
  input  logic         core_data_out_valid,
  output logic         busy,
  output logic         grant_id
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_last_grant;
  logic [7:0] r_gap_cnt;
  logic       w_sel;
  logic       w_accept;
  logic       w_resp_hs;
  logic       w_gap_done;
`ifdef AES_TIMEOUT_EN
  logic [7:0] r_wait_cnt;
  logic       w_timeout;

  assign w_timeout = (r_wait_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
  assign resp_err = 1'b0;
`endif

  assign req0_ready = (r_state == S_IDLE) && req0_valid && !w_sel;
  assign req1_ready = (r_state == S_IDLE) && req1_valid && w_sel;
  assign w_accept   = req0_ready || req1_ready;
  assign w_resp_hs  = (resp0_valid && resp0_ready) || (resp1_valid && resp1_ready);
  assign w_gap_done = (r_gap_cnt == 8'(GAP_CYCLES - 1));
  assign busy       = (r_state != S_IDLE);

  // Round-robin pick: on a tie the requester that did not win last time goes first
  always_comb begin
    w_sel = 1'b0;
    if (req0_valid && req1_valid) begin
      w_sel = ~r_last_grant;
    end else if (req1_valid) begin
      w_sel = 1'b1;
    end else begin
      w_sel = 1'b0;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = S_WAIT;
        else          w_state_nxt = S_IDLE;
      end
      S_WAIT: begin
        if (core_data_out_valid) w_state_nxt = S_RESP;
`ifdef AES_TIMEOUT_EN
        else if (w_timeout)      w_state_nxt = S_RESP;
`endif
        else                     w_state_nxt = S_WAIT;
      end
      S_RESP: begin
        if (w_resp_hs) begin
          if (GAP_CYCLES == 0) w_state_nxt = S_IDLE;
          else                 w_state_nxt = S_GAP;
        end else begin
          w_state_nxt = S_RESP;
        end
      end
      S_GAP: begin
        if (w_gap_done) w_state_nxt = S_IDLE;
        else            w_state_nxt = S_GAP;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, datapath latches and registered outputs
  always_ff @(posedge AES_clk) begin
    if (AES_rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_gap_cnt    <= 8'd0;
      core_en      <= 1'b0;
      core_data_in <= 128'd0;
      core_key_in  <= 128'd0;
      resp_data    <= 128'd0;
      resp0_valid  <= 1'b0;
      resp1_valid  <= 1'b0;
      grant_id     <= 1'b0;
`ifdef AES_TIMEOUT_EN
      r_wait_cnt   <= 8'd0;
      resp_err     <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            core_en      <= 1'b1;
            core_data_in <= w_sel ? req1_data : req0_data;
            core_key_in  <= w_sel ? req1_key  : req0_key;
            grant_id     <= w_sel;
            r_last_grant <= w_sel;
`ifdef AES_TIMEOUT_EN
            r_wait_cnt   <= 8'd0;
`endif
          end
        end
        S_WAIT: begin
          // Leaving WAIT on the first valid cycle is what makes a stretched valid count once
          if (core_data_out_valid) begin
            core_en     <= 1'b0;
            resp_data   <= core_data_out;
            resp0_valid <= ~grant_id;
            resp1_valid <= grant_id;
`ifdef AES_TIMEOUT_EN
            resp_err    <= 1'b0;
          end else if (w_timeout) begin
            core_en     <= 1'b0;
            resp_data   <= 128'd0;
            resp_err    <= 1'b1;
            resp0_valid <= ~grant_id;
            resp1_valid <= grant_id;
          end else begin
            r_wait_cnt  <= r_wait_cnt + 8'd1;
`endif
          end
        end
        S_RESP: begin
          if (w_resp_hs) begin
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
            r_gap_cnt   <= 8'd0;
          end
        end
        S_GAP: begin
          r_gap_cnt <= r_gap_cnt + 8'd1;
        end
        default: begin
          r_gap_cnt <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Scoreboard bench for aes_req_arbiter with a behavioural AES core stub.
module tb_aes_req_arbiter;

  localparam int GAP = 2;
  localparam int TMO = 64;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] D0 = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] K0 = 128'h1111222233334444555566667777aaaa;
  localparam logic [127:0] D1 = 128'hdeadbeef00000000cafef00d12345678;
  localparam logic [127:0] K1 = 128'h0f0e0d0c0b0a09080706050403020100;

  typedef struct {
    logic         id;
    logic [127:0] data;
    logic         err;
  } exp_t;

  logic         AES_clk = 1'b0;
  logic         AES_rst;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [127:0] req0_data, req0_key, req1_data, req1_key;
  logic         resp0_valid, resp0_ready, resp1_valid, resp1_ready;
  logic [127:0] resp_data;
  logic         resp_err;
  logic         core_en;
  logic [127:0] core_data_in, core_key_in, core_data_out;
  logic         core_data_out_valid;
  logic         busy, grant_id;

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last_hs = 0;
  int   acc_cnt = 0;
  int   hs_cnt = 0;
  exp_t sb[$];
  bit   grants[$];
  int   gaps[$];
  logic [127:0] acc_data = 128'd0;
  logic [127:0] acc_key = 128'd0;
  bit   exp_timeout = 1'b0;

  // core stub controls
  int   lat = 5;
  int   stretch = 1;
  bit   never = 1'b0;
  logic spur = 1'b0;
  int   en_cnt = 0;
  int   v_left = 0;
  logic core_valid = 1'b0;
  logic [127:0] core_out = 128'd0;

  aes_req_arbiter dut (
    .AES_clk(AES_clk), .AES_rst(AES_rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_key(req0_key),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_key(req1_key),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp_data(resp_data), .resp_err(resp_err),
    .core_en(core_en), .core_data_in(core_data_in), .core_key_in(core_key_in),
    .core_data_out(core_data_out), .core_data_out_valid(core_data_out_valid),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 AES_clk = ~AES_clk;

  function automatic logic [127:0] core_fn(input logic [127:0] d, input logic [127:0] k);
    if (d == FIPS_PT && k == FIPS_KEY) return FIPS_CT;
    return d ^ {k[63:0], k[127:64]} ^ 128'h5a5a5a5a_a5a5a5a5_3c3c3c3c_c3c3c3c3;
  endfunction

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // AES core stub: valid after lat enabled cycles, held for stretch cycles
  assign core_data_out_valid = core_valid | spur;
  assign core_data_out = core_out;
  always @(posedge AES_clk) begin
    if (core_en) en_cnt <= en_cnt + 1;
    else         en_cnt <= 0;
    if (core_en && !never && en_cnt == lat) begin
      core_valid <= 1'b1;
      v_left     <= stretch - 1;
      core_out   <= core_fn(core_data_in, core_key_in);
    end else if (v_left > 0) begin
      core_valid <= 1'b1;
      v_left     <= v_left - 1;
    end else begin
      core_valid <= 1'b0;
    end
  end

  // Monitor: push on acceptance, pop and compare on response handshake
  always @(negedge AES_clk) begin
    exp_t e;
    cyc++;
    if (!AES_rst) begin
      if (req0_ready || req1_ready) begin
        check_eq("ready_onehot", req0_ready & req1_ready, 1'b0);
        e.id = req1_ready;
        if (exp_timeout) begin
          e.data = 128'd0;
          e.err  = 1'b1;
        end else begin
          e.data = req1_ready ? core_fn(req1_data, req1_key) : core_fn(req0_data, req0_key);
          e.err  = 1'b0;
        end
        sb.push_back(e);
        grants.push_back(req1_ready);
        gaps.push_back(cyc - last_hs);
        acc_data = req1_ready ? req1_data : req0_data;
        acc_key  = req1_ready ? req1_key  : req0_key;
        acc_cnt++;
      end
      if ((resp0_valid && resp0_ready) || (resp1_valid && resp1_ready)) begin
        check_eq("resp_onehot", resp0_valid & resp1_valid, 1'b0);
        if (sb.size() == 0) begin
          check_eq("resp_unexpected", {resp1_valid, resp0_valid}, 2'b00);
        end else begin
          e = sb.pop_front();
          check_eq("resp_id", resp1_valid, e.id);
          check_eq("resp_data", resp_data, e.data);
          check_eq("resp_err", resp_err, e.err);
        end
        hs_cnt++;
        last_hs = cyc;
      end
      if (core_en) begin
        check_eq("core_data_stable", core_data_in, acc_data);
        check_eq("core_key_stable", core_key_in, acc_key);
      end
    end
  end

  task automatic wait_acc(input int target);
    int i = 0;
    while (acc_cnt < target && i < 200) begin
      @(posedge AES_clk); #1;
      i++;
    end
    if (acc_cnt < target) check_eq("accept_wait", acc_cnt, target);
  endtask

  task automatic wait_idle();
    int i = 0;
    while ((busy || sb.size() != 0) && i < 500) begin
      @(posedge AES_clk); #1;
      i++;
    end
    if (busy || sb.size() != 0) check_eq("idle_wait", sb.size() + int'(busy), 0);
  endtask

  task automatic do_reset();
    AES_rst = 1'b1;
    sb.delete();
    repeat (2) @(posedge AES_clk);
    #1 AES_rst = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, b, h, n;
    AES_rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = FIPS_PT; req0_key = FIPS_KEY;
    req1_data = D1; req1_key = K1;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    repeat (2) @(posedge AES_clk);
    #1 AES_rst = 1'b0;

    // reset state
    @(negedge AES_clk);
    check_eq("rst_core_en", core_en, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_resp0_valid", resp0_valid, 1'b0);
    check_eq("rst_resp1_valid", resp1_valid, 1'b0);
    check_eq("rst_resp_data", resp_data, 128'd0);
    check_eq("rst_resp_err", resp_err, 1'b0);
    check_eq("rst_grant_id", grant_id, 1'b0);
    check_eq("rst_core_data_in", core_data_in, 128'd0);

    // FIPS-197 single request
    @(posedge AES_clk); #1;
    t = acc_cnt + 1;
    req0_valid = 1'b1;
    wait_acc(t);
    req0_valid = 1'b0;
    check_eq("fips_core_en", core_en, 1'b1);
    check_eq("fips_busy", busy, 1'b1);
    wait_idle();
    check_eq("fips_resp_count", hs_cnt, 1);
    check_eq("fips_resp_data_held", resp_data, FIPS_CT);

    // simultaneous requests from reset: 0,1,0,1
    do_reset();
    req0_data = D0; req0_key = K0;
    b = grants.size();
    t = acc_cnt + 4;
    req0_valid = 1'b1; req1_valid = 1'b1;
    wait_acc(t);
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle();
    for (int k = 0; k < 4; k++) check_eq("rr_grant", grants[b + k], k % 2);
    for (int k = 1; k < 4; k++) check_eq("rr_spacing", gaps[b + k], GAP + 1);

    // response backpressure
    do_reset();
    resp0_ready = 1'b0;
    t = acc_cnt + 1;
    req0_valid = 1'b1;
    wait_acc(t);
    req0_valid = 1'b0;
    req1_valid = 1'b1;
    n = 0;
    while (!resp0_valid && n < 50) begin
      @(posedge AES_clk); #1;
      n++;
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge AES_clk);
      check_eq("bp_resp0_valid", resp0_valid, 1'b1);
      check_eq("bp_resp_data", resp_data, core_fn(D0, K0));
      check_eq("bp_req1_ready", req1_ready, 1'b0);
    end
    @(posedge AES_clk); #1;
    resp0_ready = 1'b1;
    t = acc_cnt + 1;
    wait_acc(t);
    req1_valid = 1'b0;
    check_eq("bp_req1_spacing", gaps[gaps.size() - 1], GAP + 1);
    wait_idle();

    // spurious IDLE pulse, then stretched valid in WAIT
    do_reset();
    @(posedge AES_clk); #1 spur = 1'b1;
    @(posedge AES_clk); #1 spur = 1'b0;
    @(negedge AES_clk);
    check_eq("spur_busy", busy, 1'b0);
    stretch = 3;
    h = hs_cnt;
    @(posedge AES_clk); #1;
    t = acc_cnt + 1;
    req0_valid = 1'b1;
    wait_acc(t);
    req0_valid = 1'b0;
    wait_idle();
    repeat (10) @(posedge AES_clk);
    #1;
    check_eq("stretch_one_resp", hs_cnt - h, 1);
    stretch = 1;

    // reset during WAIT
    lat = 200;
    t = acc_cnt + 1;
    req0_valid = 1'b1;
    wait_acc(t);
    req0_valid = 1'b0;
    repeat (3) @(posedge AES_clk);
    #1 AES_rst = 1'b1;
    sb.delete();
    @(posedge AES_clk); #1 AES_rst = 1'b0;
    lat = 5;
    @(negedge AES_clk);
    check_eq("mid_rst_core_en", core_en, 1'b0);
    check_eq("mid_rst_busy", busy, 1'b0);
    check_eq("mid_rst_resp0", resp0_valid, 1'b0);
    check_eq("mid_rst_resp1", resp1_valid, 1'b0);
    @(posedge AES_clk); #1;
    t = acc_cnt + 1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    wait_acc(t);
    check_eq("mid_rst_grant", grants[grants.size() - 1], 1'b0);
    req0_valid = 1'b0;
    t = acc_cnt + 1;
    wait_acc(t);
    req1_valid = 1'b0;
    wait_idle();

    // core never answers
    never = 1'b1;
`ifdef AES_TIMEOUT_EN
    exp_timeout = 1'b1;
    t = acc_cnt + 1;
    req0_valid = 1'b1;
    wait_acc(t);
    req0_valid = 1'b0;
    n = 0;
    while (!resp0_valid && n < 300) begin
      @(posedge AES_clk); #1;
      n++;
    end
    check_eq("tmo_cycles", n, TMO);
    check_eq("tmo_core_en", core_en, 1'b0);
    check_eq("tmo_err", resp_err, 1'b1);
    wait_idle();
    exp_timeout = 1'b0;
    never = 1'b0;
`else
    h = hs_cnt;
    t = acc_cnt + 1;
    req0_valid = 1'b1;
    wait_acc(t);
    req0_valid = 1'b0;
    repeat (1000) @(posedge AES_clk);
    #1;
    check_eq("no_tmo_busy", busy, 1'b1);
    check_eq("no_tmo_core_en", core_en, 1'b1);
    check_eq("no_tmo_no_resp", hs_cnt - h, 0);
    check_eq("no_tmo_resp0_valid", resp0_valid, 1'b0);
    never = 1'b0;
    do_reset();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
